// File: rtl/core_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t    : fetch sequencer states
//   XLEN             : default address / instruction width
//   RESET_PC_DEFAULT : default program counter after reset
//   PC_STEP          : byte distance between sequential instructions
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
//   imem_req / imem_addr      : read request towards instruction memory
//   imem_rvalid / imem_rdata  : single-cycle read response
//   instr_valid / instr_ready : valid/ready handshake towards decode
//   instr / instr_pc          : fetched word and its address
// master = fetch stage side, slave = memory/decode side.
interface fetch_unit_if #(
    parameter int XLEN = core_pkg::XLEN
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rvalid, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_rvalid, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next program counter selection (combinational).
//   pc          : current fetch PC
//   redirect    : taken branch or jump this cycle
//   target_addr : redirect target, low two bits ignored
//   advance     : decode accepted the held instruction
//   pc_next     : PC to load at the next clock edge
module next_pc_sel #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] target_addr,
    input  logic            advance,
    output logic [XLEN-1:0] pc_next
);
    import core_pkg::*;

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            // Force word alignment of the target.
            pc_next = target_addr & ~XLEN'(3);
        end else if (advance) begin
            // Wraps naturally modulo 2^XLEN.
            pc_next = pc + XLEN'(PC_STEP);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read at a time to
// instruction memory and presents the fetched word to decode until accepted.
//   clk, rst                 : clock, asynchronous active-high reset
//   take_branch, is_jump     : redirect requests from execute
//   target_addr              : redirect target
//   pc                       : current fetch PC
//   bus (master)             : imem request/response and decode handshake
module fetch_unit #(
    parameter int XLEN = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            take_branch,
    input  logic            is_jump,
    input  logic [XLEN-1:0] target_addr,
    output logic [XLEN-1:0] pc,
    fetch_unit_if.master    bus
);
    import core_pkg::*;

    fetch_state_t    state;
    logic            drop;
    logic            redirect;
    logic            advance;
    logic [XLEN-1:0] pc_next;

    assign redirect = take_branch | is_jump;
    assign advance  = (state == HOLD) & bus.instr_ready;

    next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
        .pc          (pc),
        .redirect    (redirect),
        .target_addr (target_addr),
        .advance     (advance),
        .pc_next     (pc_next)
    );

    // A redirect suppresses the request so the old PC is never fetched.
    assign bus.imem_req  = (state == FETCH) & ~redirect;
    assign bus.imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            drop            <= 1'b0;
            bus.instr_valid <= 1'b0;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
        end else begin
            pc <= pc_next;
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (!redirect) state <= WAIT;
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        // A response for a PC that was redirected away is stale.
                        if (drop || redirect) begin
                            drop  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            bus.instr       <= bus.imem_rdata;
                            bus.instr_pc    <= pc;
                            bus.instr_valid <= 1'b1;
                            state           <= HOLD;
                        end
                    end else if (redirect) begin
                        // Request still in flight: remember to discard it.
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect || bus.instr_ready) begin
                        bus.instr_valid <= 1'b0;
                        state           <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reference model of the fetch protocol,
// a latency-configurable instruction memory, a directed vector table and
// hand-written corner sequences, followed by randomized traffic.
module tb_fetch_unit;
    typedef struct {
        bit          br;
        bit          jmp;
        logic [31:0] tgt;
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_ipc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        take_branch = 1'b0;
    logic        is_jump = 1'b0;
    logic [31:0] target_addr = '0;
    logic [31:0] pc;

    fetch_unit_if #(.XLEN(32)) bus();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .take_branch (take_branch),
        .is_jump     (is_jump),
        .target_addr (target_addr),
        .pc          (pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // memory model
    bit          mem_pend;
    int          mem_resp;
    logic [31:0] mem_addr;
    int          lat_lo, lat_hi;
    bit          force_rv;

    // reference model of the fetcher
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_first, m_out, m_stale, m_hold;

    // per-cycle samples
    bit          s_redir, s_rdy, s_rv, s_req;
    logic [31:0] s_tgt, s_rdata, s_addr;

    vec_t tbl[17];

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + {a[15:0], a[31:16]} + 32'h0000_1001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'h0; m_instr = '0; m_ipc = '0;
        m_first = 1; m_out = 0; m_stale = 0; m_hold = 0;
        mem_pend = 0;
    endtask

    // Apply one cycle of inputs (called at the falling edge) and check outputs.
    task automatic drive(input bit br, input bit jmp, input logic [31:0] tgt, input bit rdy);
        take_branch = br;
        is_jump = jmp;
        target_addr = tgt;
        bus.instr_ready = rdy;
        s_rv = force_rv || (mem_pend && cyc == mem_resp);
        s_rdata = force_rv ? 32'hDEAD_BEEF : (s_rv ? memw(mem_addr) : 32'h0);
        bus.imem_rvalid = s_rv;
        bus.imem_rdata = s_rdata;
        s_redir = br | jmp;
        s_tgt = {tgt[31:2], 2'b00};
        s_rdy = rdy;
        #1;
        s_req = bus.imem_req;
        s_addr = bus.imem_addr;
        chk("pc", pc, m_pc);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("imem_req", 32'(bus.imem_req), 32'(!m_first && !m_out && !m_hold && !s_redir));
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_hold));
        chk("one_outstanding", 32'(s_req && mem_pend), 32'h0);
        if (m_hold) begin
            chk("instr", bus.instr, m_instr);
            chk("instr_pc", bus.instr_pc, m_ipc);
        end
    endtask

    // Clock edge: update memory and reference model from the sampled inputs.
    task automatic advance();
        @(posedge clk);
        if (s_rv) mem_pend = 0;
        if (s_req) begin
            mem_pend = 1;
            mem_resp = cyc + int'($urandom_range(lat_lo, lat_hi));
            mem_addr = s_addr;
        end
        if (m_first) begin
            m_first = 0;
            if (s_redir) m_pc = s_tgt;
        end else if (m_hold) begin
            if (s_redir) begin m_hold = 0; m_pc = s_tgt; end
            else if (s_rdy) begin m_hold = 0; m_pc = m_pc + 32'd4; end
        end else if (m_out) begin
            if (s_rv) begin
                m_out = 0;
                if (!m_stale && !s_redir) begin
                    m_hold = 1; m_instr = s_rdata; m_ipc = m_pc;
                end
                m_stale = 0;
                if (s_redir) m_pc = s_tgt;
            end else if (s_redir) begin
                m_pc = s_tgt; m_stale = 1;
            end
        end else begin
            if (s_redir) m_pc = s_tgt;
            else m_out = 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic cycle(input bit br, input bit jmp, input logic [31:0] tgt, input bit rdy);
        drive(br, jmp, tgt, rdy);
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found, got, first_req_seen, stale_valid;

        bus.instr_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        lat_lo = 1; lat_hi = 1; force_rv = 0;
        m_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        @(negedge clk);
        rst = 0;

        // Directed table: sequential fetch, jump in HOLD, wrap at top of memory
        tbl[0]  = '{0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0};
        tbl[1]  = '{0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0};
        tbl[2]  = '{0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0};
        tbl[3]  = '{0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0};
        tbl[4]  = '{0, 0, 32'h0,         1, 1, 32'h4,         0, 32'h0};
        tbl[5]  = '{0, 0, 32'h0,         1, 0, 32'h4,         0, 32'h0};
        tbl[6]  = '{0, 0, 32'h0,         1, 0, 32'h4,         1, 32'h4};
        tbl[7]  = '{0, 0, 32'h0,         1, 1, 32'h8,         0, 32'h0};
        tbl[8]  = '{0, 0, 32'h0,         1, 0, 32'h8,         0, 32'h0};
        tbl[9]  = '{0, 1, 32'h203,       1, 0, 32'h8,         1, 32'h8};
        tbl[10] = '{1, 0, 32'hFFFF_FFFF, 1, 0, 32'h200,       0, 32'h0};
        tbl[11] = '{0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0};
        tbl[12] = '{0, 0, 32'h0,         1, 0, 32'hFFFF_FFFC, 0, 32'h0};
        tbl[13] = '{0, 0, 32'h0,         1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC};
        tbl[14] = '{0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0};
        tbl[15] = '{0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0};
        tbl[16] = '{0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0};
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].br, tbl[i].jmp, tbl[i].tgt, tbl[i].rdy);
            chk("tbl_req", 32'(bus.imem_req), 32'(tbl[i].e_req));
            chk("tbl_addr", bus.imem_addr, tbl[i].e_addr);
            chk("tbl_valid", 32'(bus.instr_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk("tbl_instr_pc", bus.instr_pc, tbl[i].e_ipc);
                chk("tbl_instr", bus.instr, memw(tbl[i].e_ipc));
            end
            advance();
        end

        // Decode stalls in HOLD for five more cycles
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 32'h0, 0);
            chk("hold_valid", 32'(bus.instr_valid), 32'h1);
            chk("hold_instr", bus.instr, memw(32'h0));
            chk("hold_instr_pc", bus.instr_pc, 32'h0);
            chk("hold_req", 32'(bus.imem_req), 32'h0);
            chk("hold_pc", pc, 32'h0);
            advance();
        end
        drive(0, 0, 32'h0, 1);
        chk("hold_pc_ready_cycle", pc, 32'h0);
        advance();
        drive(0, 0, 32'h0, 1);
        chk("hold_pc_after", pc, 32'h4);
        chk("hold_req_after", 32'(bus.imem_req), 32'h1);
        advance();

        // Redirect while a slow response is outstanding
        lat_lo = 4; lat_hi = 4;
        cycle(1, 0, 32'h0, 1);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            drive(0, 0, 32'h0, 1);
            if (s_req && s_addr == 32'h8) found = 1;
            advance();
        end
        chk("t3_req8_found", 32'(found), 32'h1);
        drive(1, 0, 32'h100, 1);
        advance();
        got = 0; first_req_seen = 0; stale_valid = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            drive(0, 0, 32'h0, 1);
            if (!first_req_seen && bus.instr_valid) stale_valid = 1;
            if (s_req && !first_req_seen) begin
                first_req_seen = 1;
                chk("t3_next_addr", s_addr, 32'h100);
            end
            if (bus.instr_valid && first_req_seen) begin
                got = 1;
                chk("t3_instr_pc", bus.instr_pc, 32'h100);
                chk("t3_instr", bus.instr, memw(32'h100));
            end
            advance();
        end
        chk("t3_stale_dropped", 32'(stale_valid), 32'h0);
        chk("t3_delivered", 32'(got), 32'h1);

        // Asynchronous reset in the middle of WAIT
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            drive(0, 0, 32'h0, 1);
            if (s_req) found = 1;
            advance();
        end
        chk("t6_req_found", 32'(found), 32'h1);
        drive(0, 0, 32'h0, 1);
        #2 rst = 1;
        #1;
        chk("t6_rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("t6_rst_req", 32'(bus.imem_req), 32'h0);
        chk("t6_rst_pc", pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        m_reset();
        cyc++;
        force_rv = 1;
        drive(0, 0, 32'h0, 1);
        chk("t6_idle_req", 32'(bus.imem_req), 32'h0);
        advance();
        force_rv = 0;
        drive(0, 0, 32'h0, 1);
        chk("t6_first_req", 32'(bus.imem_req), 32'h1);
        chk("t6_first_addr", bus.imem_addr, 32'h0);
        advance();
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(0, 0, 32'h0, 1);
            if (bus.instr_valid) begin
                got = 1;
                chk("t6_instr_pc", bus.instr_pc, 32'h0);
                chk("t6_instr", bus.instr, memw(32'h0));
            end
            advance();
        end
        chk("t6_delivered", 32'(got), 32'h1);

        // Randomized traffic against the reference model
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 600; i++) begin
            bit br, jmp, rdy;
            logic [31:0] tgt;
            br  = ($urandom_range(0, 9) == 0);
            jmp = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            tgt = $urandom;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8 | (tgt & 32'h7);
            cycle(br, jmp, tgt, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
